uart_rcvr: RTL and testbench

- Serial receiver that consumes the `Serial_out` line produced by `UART_XMTR`.
- Recovers 1-start / WORD_SIZE-data (LSB first) / 1-stop frames by mid-bit sampling at CLKS_PER_BIT clocks per bit.
- Presents each byte on a parallel register with a valid/ack handshake.
- Flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rcvr.sv | 148 ++++++++++++++
 tb/tb_uart_rcvr.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, line levels and default frame geometry
// shared by the UART transmitter and receiver.
package uart_pkg;

    localparam int DEF_WORD_SIZE    = 8;
    localparam int DEF_CLKS_PER_BIT = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } rcvr_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Resets to the idle (stop) level so the receiver never sees a false start.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_rx
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= STOP_BIT;
            r_sync <= STOP_BIT;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
        end
    end

    assign o_rx = r_sync;

endmodule

// File: rtl/uart_rcvr.sv
// uart_rcvr: mid-bit sampling UART receiver with a valid/ack output
// register and sticky framing/overrun flags.
module uart_rcvr
    import uart_pkg::*;
#(
    parameter int WORD_SIZE    = DEF_WORD_SIZE,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                 Clock,
    input  logic                 rst,
    input  logic                 Serial_in,
    input  logic                 Read_ack,
    output logic [WORD_SIZE-1:0] RCV_datareg,
    output logic                 RCV_valid,
    output logic                 Busy,
    output logic                 Error_frame,
    output logic                 Error_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WORD_SIZE + 1);

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE - 1);

    rcvr_state_t          r_state;
    rcvr_state_t          w_next;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic [WORD_SIZE-1:0] r_shift;
    logic                 r_load;
    logic                 w_rx;
    logic                 w_half;
    logic                 w_full;
    logic                 w_shift;
    logic                 w_good;
    logic                 w_ferr;

    uart_rx_sync u_sync (
        .i_clk (Clock),
        .i_rst (rst),
        .i_rx  (Serial_in),
        .o_rx  (w_rx)
    );

    assign w_half = (r_cnt == HALF_M1);
    assign w_full = (r_cnt == FULL_M1);

    always_ff @(posedge Clock) begin
        if (rst) r_state <= WAIT_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            WAIT_IDLE: if (w_rx == STOP_BIT) w_next = IDLE;
            IDLE:      if (w_rx == START_BIT) w_next = START;
            START: begin
                if (w_half)
                    w_next = (w_rx == START_BIT) ? DATA : IDLE;
            end
            DATA: begin
                if (w_full && r_bit == LAST_BIT)
                    w_next = STOP;
            end
            STOP: begin
                if (w_full)
                    w_next = (w_rx == STOP_BIT) ? IDLE : WAIT_IDLE;
            end
            default:   w_next = WAIT_IDLE;
        endcase
    end

    always_comb begin
        Busy    = 1'b0;
        w_shift = 1'b0;
        w_good  = 1'b0;
        w_ferr  = 1'b0;
        unique case (r_state)
            START: Busy = 1'b1;
            DATA: begin
                Busy    = 1'b1;
                w_shift = w_full;
            end
            STOP: begin
                Busy   = 1'b1;
                w_good = w_full && (w_rx == STOP_BIT);
                w_ferr = w_full && (w_rx != STOP_BIT);
            end
            default: ;
        endcase
    end

    // Counters restart on every state change so they never wrap.
    always_ff @(posedge Clock) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_load  <= 1'b0;
        end else begin
            r_load <= w_good;
            if (r_state != w_next) begin
                r_cnt <= '0;
                r_bit <= '0;
            end else if (w_shift) begin
                r_cnt <= '0;
                r_bit <= r_bit + BW'(1);
            end else if (Busy) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_shift)
                r_shift <= {w_rx, r_shift[WORD_SIZE-1:1]};
        end
    end

    // A load coinciding with Read_ack replaces the byte and clears errors.
    always_ff @(posedge Clock) begin
        if (rst) begin
            RCV_datareg   <= '0;
            RCV_valid     <= 1'b0;
            Error_frame   <= 1'b0;
            Error_overrun <= 1'b0;
        end else begin
            if (r_load) begin
                if (RCV_valid && !Read_ack) begin
                    Error_overrun <= 1'b1;
                end else begin
                    RCV_datareg <= r_shift;
                    RCV_valid   <= 1'b1;
                    if (Read_ack) begin
                        Error_frame   <= 1'b0;
                        Error_overrun <= 1'b0;
                    end
                end
            end else if (Read_ack) begin
                RCV_valid     <= 1'b0;
                Error_frame   <= 1'b0;
                Error_overrun <= 1'b0;
            end
            if (w_ferr)
                Error_frame <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rcvr.sv
// tb_uart_rcvr: directed scenario tests for uart_rcvr at the default
// geometry (8 data bits, 8 clocks per bit).
module tb_uart_rcvr;

    logic       Clock = 1'b0;
    logic       rst;
    logic       Serial_in;
    logic       Read_ack;
    logic [7:0] RCV_datareg;
    logic       RCV_valid;
    logic       Busy;
    logic       Error_frame;
    logic       Error_overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = -1;
    logic prev_valid = 1'b0;

    uart_rcvr #(
        .WORD_SIZE    (8),
        .CLKS_PER_BIT (8)
    ) dut (
        .Clock         (Clock),
        .rst           (rst),
        .Serial_in     (Serial_in),
        .Read_ack      (Read_ack),
        .RCV_datareg   (RCV_datareg),
        .RCV_valid     (RCV_valid),
        .Busy          (Busy),
        .Error_frame   (Error_frame),
        .Error_overrun (Error_overrun)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (RCV_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = RCV_valid;
    end

    task automatic send_bit(input logic b);
        Serial_in = b;
        repeat (8) @(negedge Clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic ack_pulse();
        Read_ack = 1'b1;
        @(negedge Clock);
        Read_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        Serial_in = 1'b1;
        Read_ack = 1'b0;
        repeat (3) @(negedge Clock);
        checks++;
        if ({RCV_datareg, RCV_valid, Busy, Error_frame, Error_overrun} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h v=%b busy=%b fe=%b oe=%b, want all 0",
                     RCV_datareg, RCV_valid, Busy, Error_frame, Error_overrun);
        end
        rst = 1'b0;
        repeat (5) @(negedge Clock);
    endtask

    task automatic test_single_frame();
        int start_cyc;
        rise_cyc = -1;
        start_cyc = cyc;
        send_frame(8'h41, 1'b1);
        @(negedge Clock);
        checks++;
        if (RCV_datareg !== 8'h41 || RCV_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_data: got %h v=%b, want 41 v=1", RCV_datareg, RCV_valid);
        end
        checks++;
        if (rise_cyc - start_cyc - 1 !== 79) begin
            errors++;
            $display("FAIL single_latency: got %0d clocks, want 79", rise_cyc - start_cyc - 1);
        end
        checks++;
        if (Error_frame !== 1'b0 || Error_overrun !== 1'b0) begin
            errors++;
            $display("FAIL single_errors: got fe=%b oe=%b, want 0 0", Error_frame, Error_overrun);
        end
        ack_pulse();
        checks++;
        if (RCV_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: got v=%b, want 0", RCV_valid);
        end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 0; i < 5; i++) send_frame(8'h41 + 8'(i), 1'b1);
                Serial_in = 1'b1;
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    int waited;
                    logic [7:0] exp;
                    waited = 0;
                    exp = 8'h41 + 8'(k);
                    while (RCV_valid !== 1'b1 && waited < 200) begin
                        @(negedge Clock);
                        waited++;
                    end
                    checks++;
                    if (RCV_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_valid[%0d]: got v=%b after %0d clocks, want 1",
                                 k, RCV_valid, waited);
                    end
                    checks++;
                    if (RCV_datareg !== exp) begin
                        errors++;
                        $display("FAIL b2b_data[%0d]: got %h, want %h", k, RCV_datareg, exp);
                    end
                    ack_pulse();
                end
            end
        join
        checks++;
        if (Error_overrun !== 1'b0 || Error_frame !== 1'b0) begin
            errors++;
            $display("FAIL b2b_errors: got fe=%b oe=%b, want 0 0", Error_frame, Error_overrun);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h42, 1'b1);
        checks++;
        if (RCV_datareg !== 8'h42 || RCV_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_first: got %h v=%b, want 42 v=1", RCV_datareg, RCV_valid);
        end
        send_frame(8'h43, 1'b1);
        repeat (2) @(negedge Clock);
        checks++;
        if (RCV_datareg !== 8'h42 || RCV_valid !== 1'b1 || Error_overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flag: got %h v=%b oe=%b, want 42 v=1 oe=1",
                     RCV_datareg, RCV_valid, Error_overrun);
        end
        ack_pulse();
        checks++;
        if (RCV_valid !== 1'b0 || Error_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_ack: got v=%b oe=%b, want 0 0", RCV_valid, Error_overrun);
        end
    endtask

    task automatic test_framing();
        logic [7:0] d;
        d = 8'h44;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        Serial_in = 1'b0;
        repeat (20) @(negedge Clock);
        checks++;
        if (Error_frame !== 1'b1 || RCV_valid !== 1'b0 || RCV_datareg !== 8'h42) begin
            errors++;
            $display("FAIL frame_flag: got fe=%b v=%b data=%h, want fe=1 v=0 data=42",
                     Error_frame, RCV_valid, RCV_datareg);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_lockout: got busy=%b while line low, want 0", Busy);
        end
        Serial_in = 1'b1;
        repeat (8) @(negedge Clock);
        send_frame(8'h43, 1'b1);
        @(negedge Clock);
        checks++;
        if (RCV_datareg !== 8'h43 || RCV_valid !== 1'b1 || Error_frame !== 1'b1) begin
            errors++;
            $display("FAIL frame_recover: got %h v=%b fe=%b, want 43 v=1 fe=1",
                     RCV_datareg, RCV_valid, Error_frame);
        end
        ack_pulse();
        checks++;
        if (Error_frame !== 1'b0 || RCV_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_ack: got fe=%b v=%b, want 0 0", Error_frame, RCV_valid);
        end
    endtask

    task automatic test_glitch();
        Serial_in = 1'b0;
        repeat (2) @(negedge Clock);
        Serial_in = 1'b1;
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start: got busy=%b, want 1", Busy);
        end
        repeat (12) @(negedge Clock);
        checks++;
        if ({Busy, RCV_valid, Error_frame, Error_overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL glitch_reject: got busy=%b v=%b fe=%b oe=%b, want all 0",
                     Busy, RCV_valid, Error_frame, Error_overrun);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h45;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        Serial_in = d[4];
        repeat (4) @(negedge Clock);
        rst = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if ({RCV_datareg, RCV_valid, Busy, Error_frame, Error_overrun} !== 12'h000) begin
            errors++;
            $display("FAIL midrst_outputs: got data=%h v=%b busy=%b fe=%b oe=%b, want all 0",
                     RCV_datareg, RCV_valid, Busy, Error_frame, Error_overrun);
        end
        rst = 1'b0;
        @(negedge Clock);
        Serial_in = 1'b1;
        repeat (16) @(negedge Clock);
        checks++;
        if ({RCV_datareg, RCV_valid, Busy, Error_frame, Error_overrun} !== 12'h000) begin
            errors++;
            $display("FAIL midrst_ignored: got data=%h v=%b busy=%b fe=%b oe=%b, want all 0",
                     RCV_datareg, RCV_valid, Busy, Error_frame, Error_overrun);
        end
        send_frame(8'h41, 1'b1);
        @(negedge Clock);
        checks++;
        if (RCV_datareg !== 8'h41 || RCV_valid !== 1'b1 ||
            Error_frame !== 1'b0 || Error_overrun !== 1'b0) begin
            errors++;
            $display("FAIL midrst_next: got %h v=%b fe=%b oe=%b, want 41 v=1 fe=0 oe=0",
                     RCV_datareg, RCV_valid, Error_frame, Error_overrun);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_glitch();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
